// File: rtl/vp_pkg.sv
// rtl/vp_pkg.sv - shared VP encoder/decoder widths, lane types and helpers
//
// Purpose : constants and types common to the VP encoder and decoder.
// Ports   : none (package).
package vp_pkg;

  localparam int NUM_LANE = 3;
  localparam int DATA_W   = 16;
  localparam int COORD_W  = 7;
  localparam int PROD_W   = 2 * DATA_W;
  localparam int PSUM_W   = 2 * DATA_W + 2;   // two guard bits cover a 3-way merge
  localparam int CNT_W    = 16;

  typedef logic        [2:0][COORD_W-1:0] vp_addr_t;
  typedef logic signed [DATA_W-1:0]       vp_data_t;
  typedef logic signed [PROD_W-1:0]       vp_prod_t;
  typedef logic signed [PSUM_W-1:0]       vp_psum_t;

  // One buffer's worth of lanes as handed over by the encoder.
  typedef struct packed {
    vp_addr_t [NUM_LANE-1:0] addr;
    vp_data_t [NUM_LANE-1:0] w;
    vp_data_t [NUM_LANE-1:0] ia;
  } vp_group_t;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/vp_lane_merge.sv
// rtl/vp_lane_merge.sv - combinational 3-lane address-equality merge
//
// Purpose : folds products of lanes sharing a target address into the lowest
//           such lane; later duplicates are suppressed.
// Ports   : i_valid  group present
//           i_v      per-lane non-padding flag
//           i_addr   per-lane target address
//           i_prod   per-lane signed product
//           o_valid  per-lane update valid after merge
//           o_addr   per-lane address (0 when lane not valid)
//           o_psum   per-lane merged sum (0 when lane not valid)
module vp_lane_merge
  import vp_pkg::*;
(
  input  logic                    i_valid,
  input  logic [NUM_LANE-1:0]     i_v,
  input  vp_addr_t [NUM_LANE-1:0] i_addr,
  input  vp_prod_t [NUM_LANE-1:0] i_prod,
  output logic [NUM_LANE-1:0]     o_valid,
  output vp_addr_t [NUM_LANE-1:0] o_addr,
  output vp_psum_t [NUM_LANE-1:0] o_psum
);

  logic w_eq01, w_eq02, w_eq12;
  logic [NUM_LANE-1:0] w_lane_v;
  vp_psum_t [NUM_LANE-1:0] w_px;
  vp_psum_t [NUM_LANE-1:0] w_sum;

  assign w_eq01 = i_v[0] & i_v[1] & (i_addr[0] == i_addr[1]);
  assign w_eq02 = i_v[0] & i_v[2] & (i_addr[0] == i_addr[2]);
  assign w_eq12 = i_v[1] & i_v[2] & (i_addr[1] == i_addr[2]);

  assign w_lane_v[0] = i_valid & i_v[0];
  assign w_lane_v[1] = i_valid & i_v[1] & ~w_eq01;
  assign w_lane_v[2] = i_valid & i_v[2] & ~w_eq02 & ~w_eq12;

  always_comb begin
    w_px = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      w_px[i] = vp_psum_t'($signed(i_prod[i]));   // sign-extend before summing
    end
    w_sum[0] = w_px[0] + (w_eq01 ? w_px[1] : '0) + (w_eq02 ? w_px[2] : '0);
    w_sum[1] = w_px[1] + (w_eq12 ? w_px[2] : '0);
    w_sum[2] = w_px[2];
  end

  always_comb begin
    o_valid = w_lane_v;
    o_addr  = '0;
    o_psum  = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (w_lane_v[i]) begin
        o_addr[i] = i_addr[i];
        o_psum[i] = w_sum[i];
      end
    end
  end

endmodule

// File: rtl/vp_decoder.sv
// rtl/vp_decoder.sv - VP ping-pong consumer: capture, multiply, merge, count
//
// Purpose : detects right/left buffer-ready rising edges, captures the 3-lane
//           group, multiplies w*ia per lane and emits merged (addr, psum)
//           updates three cycles after the edge.
// Ports   : i_clk, i_rst_n (async, active-low), i_clear (sync counter clear)
//           i_right_ready/i_left_ready    buffer-ready levels
//           i_addr_*/i_w_*/i_ia_*          buffer lanes per side
//           o_valid/o_addr/o_psum          per-lane registered updates
//           o_busy                         pipeline or pending slot occupied
//           o_group_cnt/o_mac_cnt          groups / non-padding lanes since clear
module vp_decoder
  import vp_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_right_ready,
  input  logic                    i_left_ready,
  input  vp_addr_t [NUM_LANE-1:0] i_addr_right,
  input  vp_data_t [NUM_LANE-1:0] i_w_right,
  input  vp_data_t [NUM_LANE-1:0] i_ia_right,
  input  vp_addr_t [NUM_LANE-1:0] i_addr_left,
  input  vp_data_t [NUM_LANE-1:0] i_w_left,
  input  vp_data_t [NUM_LANE-1:0] i_ia_left,
  output logic [NUM_LANE-1:0]     o_valid,
  output vp_addr_t [NUM_LANE-1:0] o_addr,
  output vp_psum_t [NUM_LANE-1:0] o_psum,
  output logic                    o_busy,
  output logic [CNT_W-1:0]        o_group_cnt,
  output logic [CNT_W-1:0]        o_mac_cnt
);

  logic r_right_prev, r_left_prev;
  logic r_pend_full;
  vp_group_t r_pend;

  logic r_c_valid;
  logic [NUM_LANE-1:0] r_c_v;
  vp_group_t r_c_grp;

  logic r_m_valid;
  logic [NUM_LANE-1:0] r_m_v;
  vp_addr_t [NUM_LANE-1:0] r_m_addr;
  vp_prod_t [NUM_LANE-1:0] r_m_prod;

  logic r_o_grp_valid;
  logic [NUM_LANE-1:0] r_o_valid;
  vp_addr_t [NUM_LANE-1:0] r_o_addr;
  vp_psum_t [NUM_LANE-1:0] r_o_psum;

  logic [CNT_W-1:0] r_group_cnt, r_mac_cnt;

  logic w_rise_r, w_rise_l, w_cap_valid, w_pend_load;
  vp_group_t w_right_grp, w_left_grp, w_cap_grp;
  logic [NUM_LANE-1:0] w_cap_v;
  vp_prod_t [NUM_LANE-1:0] w_prod;
  logic [NUM_LANE-1:0] w_mg_valid;
  vp_addr_t [NUM_LANE-1:0] w_mg_addr;
  vp_psum_t [NUM_LANE-1:0] w_mg_psum;

  assign w_rise_r = i_right_ready & ~r_right_prev;
  assign w_rise_l = i_left_ready  & ~r_left_prev;

  assign w_right_grp = '{addr: i_addr_right, w: i_w_right, ia: i_ia_right};
  assign w_left_grp  = '{addr: i_addr_left,  w: i_w_left,  ia: i_ia_left};

  // Right edge first, then a parked left group, then a lone left edge.
  // The encoder protocol guarantees a parked group never collides with a new edge.
  assign w_pend_load = w_rise_r & w_rise_l;
  assign w_cap_valid = w_rise_r | r_pend_full | w_rise_l;

  always_comb begin
    if (w_rise_r)         w_cap_grp = w_right_grp;
    else if (r_pend_full) w_cap_grp = r_pend;
    else                  w_cap_grp = w_left_grp;
    w_cap_v = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      w_cap_v[i] = (w_cap_grp.w[i] != '0);   // zero weight marks encoder padding
    end
  end

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      w_prod[i] = vp_prod_t'($signed(r_c_grp.w[i])) * vp_prod_t'($signed(r_c_grp.ia[i]));
    end
  end

  vp_lane_merge u_merge (
    .i_valid (r_m_valid),
    .i_v     (r_m_v),
    .i_addr  (r_m_addr),
    .i_prod  (r_m_prod),
    .o_valid (w_mg_valid),
    .o_addr  (w_mg_addr),
    .o_psum  (w_mg_psum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_right_prev  <= 1'b0;
      r_left_prev   <= 1'b0;
      r_pend_full   <= 1'b0;
      r_pend        <= '0;
      r_c_valid     <= 1'b0;
      r_c_v         <= '0;
      r_c_grp       <= '0;
      r_m_valid     <= 1'b0;
      r_m_v         <= '0;
      r_m_addr      <= '0;
      r_m_prod      <= '0;
      r_o_grp_valid <= 1'b0;
      r_o_valid     <= '0;
      r_o_addr      <= '0;
      r_o_psum      <= '0;
      r_group_cnt   <= '0;
      r_mac_cnt     <= '0;
    end else begin
      r_right_prev <= i_right_ready;
      r_left_prev  <= i_left_ready;

      r_pend_full <= w_pend_load | (r_pend_full & w_rise_r);
      if (w_pend_load) r_pend <= w_left_grp;

      r_c_valid <= w_cap_valid;
      r_c_v     <= w_cap_valid ? w_cap_v : '0;
      r_c_grp   <= w_cap_grp;

      r_m_valid <= r_c_valid;
      r_m_v     <= r_c_v;
      r_m_addr  <= r_c_grp.addr;
      r_m_prod  <= w_prod;

      r_o_grp_valid <= r_m_valid;
      r_o_valid     <= w_mg_valid;
      r_o_addr      <= w_mg_addr;
      r_o_psum      <= w_mg_psum;

      if (i_clear) begin
        r_group_cnt <= '0;
        r_mac_cnt   <= '0;
      end else if (w_cap_valid) begin
        r_group_cnt <= r_group_cnt + 1'b1;
        r_mac_cnt   <= r_mac_cnt + CNT_W'(popcount3(w_cap_v));
      end
    end
  end

  assign o_valid     = r_o_valid;
  assign o_addr      = r_o_addr;
  assign o_psum      = r_o_psum;
  assign o_busy      = r_pend_full | r_c_valid | r_m_valid | r_o_grp_valid;
  assign o_group_cnt = r_group_cnt;
  assign o_mac_cnt   = r_mac_cnt;

endmodule
